clock_time_keeper: RTL and testbench
====================================

Name: clock_time_keeper

Overview:
- Downstream of the setup-value entry stage.
- Accepts a decimal setup number HHMMSS as a 40-bit binary value (e.g. 123045 means 12:30:45) and converts it to packed BCD with an iterative double-dabble.
- Validates the result, loads it into the running time, then advances the time once per second from a prescaled system clock.
- BCD outputs feed the seven-segment display driver.

Parameters:
- CLK_FREQ_HZ, 50_000_000: i_clk frequency. The prescaler divides by this value to produce a 1 Hz tick.
- SETUP_W, 40: width of i_setup_value.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_setup_value  in  SETUP_W  binary setup number HHMMSS.
- i_load  in  1  synchronous single-cycle load request.
- i_run  in  1  1 = time advances on tick; 0 = time frozen, prescaler held at 0.
- o_hh_bcd  out  8  hours, two BCD digits.
- o_mm_bcd  out  8  minutes, two BCD digits.
- o_ss_bcd  out  8  seconds, two BCD digits.
- o_sec_tick  out  1  one-cycle pulse on every time increment.
- o_busy  out  1  conversion/check in progress.
- o_load_err  out  1  sticky flag: last load was rejected.

Behaviour:
- Reset (async, i_rst=1):
  - All time registers = 8'h00; prescaler = 0; state = IDLE.
  - o_sec_tick = 0, o_busy = 0, o_load_err = 0.
  - Reset mid-conversion aborts it with no partial load.
- States: IDLE (counting) -> CONVERT -> CHECK -> IDLE.
- IDLE:
  - Prescaler counts 0..CLK_FREQ_HZ-1 while i_run=1.
  - At terminal count: prescaler wraps to 0, time +1 s, o_sec_tick=1 for exactly one cycle.
  - Seconds 59->00 carries into minutes; minutes 59->00 carries into hours; 23:59:59 -> 00:00:00.
  - All increments are BCD-correct: 09->10, never 0A.
- Load acceptance:
  - i_load=1 in IDLE (cycle 0) -> state CONVERT.
  - o_busy=1 from cycle 1 through the CHECK cycle.
  - i_load while o_busy=1 is ignored.
- Range check at acceptance: if i_setup_value > 999999 (any bit above bit 19 set, or low 20 bits > 999999), go straight to CHECK-fail.
- CONVERT: 20 iterations of shift/add-3 over the low 20 bits, one per cycle, giving 24-bit packed BCD.
- CHECK (1 cycle):
  - Valid when hours < 8'h24, minutes < 8'h60 and seconds < 8'h60.
  - Valid: time registers load on the edge leaving CHECK (cycle 22 after acceptance), prescaler reset to 0, o_load_err cleared.
  - Invalid: time unchanged, o_load_err set.
- Ticks while busy:
  - Time is not incremented and no o_sec_tick is issued; the prescaler keeps counting.
  - A successful load restarts the second.
  - A rejected load drops at most one tick.
- i_run=0 during a load: the load still completes. The clock stays frozen afterwards.
- A tick and i_load in the same IDLE cycle: the tick increments the time, then the load proceeds and overwrites it if valid.

Optional Feature:
- Macro: CLOCK_12H_DISPLAY_EN.
- Defined:
  - o_hh_bcd presents 12-hour format. Internal hour 00 -> 8'h12, 13..23 -> 01..11.
  - Extra output o_pm (1 bit) is 1 when internal hours >= 12.
  - Internal counting and load validation remain 24-hour.
- Undefined: 24-hour output only; no o_pm port.

Decomposition:
- Package digital_clock_pkg:
  - state enum (IDLE, CONVERT, CHECK).
  - BCD limits HR_LIMIT=8'h24, MS_LIMIT=8'h60.
  - MAX_SETUP=999999.
  - BIN_W=20, BCD_W=24.
- Sub-module bin2bcd_seq: start/busy/done handshake, 20-bit input, 24-bit packed BCD output, 20-cycle latency. It is instantiated once.
- Prescaler and the time counter stay inline.

Test Plan (CLK_FREQ_HZ=10 in bench):
- Reset, i_run=1, run 600 cycles -> 00:01:00; o_sec_tick pulsed 60 times, each 1 cycle wide.
- Load 123045 -> o_busy high for 21 cycles; at cycle 22 outputs 8'h12/8'h30/8'h45, o_load_err=0; 10 cycles later ss=8'h46.
- Load 235958, run 20 cycles -> 23:59:59 then 00:00:00 (check the 09->10 style carries).
- Load 246000, then 1000000 -> time unchanged, o_load_err=1; a following valid load of 000001 clears it.
- Assert i_rst at cycle 10 of a conversion -> all outputs 0 immediately; no load occurs after release.
- With CLOCK_12H_DISPLAY_EN: load 000000 -> hh=8'h12, o_pm=0; load 130000 -> hh=8'h01, o_pm=1.

Source files
------------

// File: rtl/digital_clock_pkg.sv
// Shared types, limits and BCD helpers for the clock time keeper.
// The 12-hour display helper is only referenced when CLOCK_12H_DISPLAY_EN is defined.
package digital_clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    CHECK
  } state_e;

  localparam logic [7:0]  HR_LIMIT  = 8'h24;
  localparam logic [7:0]  MS_LIMIT  = 8'h60;
  localparam int unsigned MAX_SETUP = 999999;
  localparam int unsigned BIN_W     = 20;
  localparam int unsigned BCD_W     = 24;

  // Two-digit BCD increment; returns {wrapped, next}. Wraps to 00 after 'last'.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last) begin
      return 9'h100;
    end
    if (v[3:0] == 4'd9) begin
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    end
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // 24-hour BCD hour to 12-hour BCD hour (00 -> 12, 13..23 -> 01..11).
  function automatic logic [7:0] hour_to_12h(input logic [7:0] h24);
    logic [4:0] bin;
    bin = 5'(h24[7:4]) * 5'd10 + 5'(h24[3:0]);
    if (bin == 5'd0) begin
      bin = 5'd12;
    end else if (bin > 5'd12) begin
      bin = bin - 5'd12;
    end
    if (bin >= 5'd10) begin
      return {4'd1, 4'(bin - 5'd10)};
    end
    return {4'd0, bin[3:0]};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift/add-3 step per cycle over BIN_W bits.
// done_o marks the cycle whose closing edge writes the final BCD result.
module bin2bcd_seq
  import digital_clock_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int unsigned CNT_W = $clog2(BIN_W);

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] step;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             last;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign step = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign last = busy_q && (cnt_q == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (busy_q) begin
      bin_q <= {bin_q[BIN_W-2:0], 1'b0};
      bcd_q <= step;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last) begin
        busy_q <= 1'b0;
      end
    end else if (start_i) begin
      bin_q  <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end
  end

  assign busy_o = busy_q;
  assign done_o = last;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/clock_time_keeper.sv
// HH:MM:SS time keeper with binary setup-value load via sequential BCD conversion.
// Optional CLOCK_12H_DISPLAY_EN: 12-hour hour display plus o_pm output.
module clock_time_keeper
  import digital_clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned SETUP_W     = 40
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [SETUP_W-1:0] i_setup_value,
  input  logic               i_load,
  input  logic               i_run,
  output logic [7:0]         o_hh_bcd,
  output logic [7:0]         o_mm_bcd,
  output logic [7:0]         o_ss_bcd,
  output logic               o_sec_tick,
  output logic               o_busy,
`ifdef CLOCK_12H_DISPLAY_EN
  output logic               o_pm,
`endif
  output logic               o_load_err
);

  localparam int unsigned      PRE_W   = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ_HZ - 1);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] presc_q;
  logic [7:0]       hh_q, mm_q, ss_q;
  logic             tick_q, err_q, range_err_q;

  logic             accept, in_range, conv_start;
  logic             conv_busy, conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic [7:0]       cand_hh, cand_mm, cand_ss;
  logic             load_ok, load_commit;
  logic             presc_wrap, sec_inc;
  logic [8:0]       ss_nxt, mm_nxt, hh_nxt;

  assign accept     = (state_q == IDLE) && i_load;
  assign in_range   = ~|i_setup_value[SETUP_W-1:BIN_W] &&
                      (i_setup_value[BIN_W-1:0] <= BIN_W'(MAX_SETUP));
  assign conv_start = accept && in_range;

  bin2bcd_seq u_bin2bcd (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .start_i (conv_start),
    .bin_i   (i_setup_value[BIN_W-1:0]),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  assign cand_hh = conv_bcd[23:16];
  assign cand_mm = conv_bcd[15:8];
  assign cand_ss = conv_bcd[7:0];

  // An out-of-range request never starts the converter, so its stale result is masked.
  assign load_ok     = !range_err_q && (cand_hh < HR_LIMIT) &&
                       (cand_mm < MS_LIMIT) && (cand_ss < MS_LIMIT);
  assign load_commit = (state_q == CHECK) && load_ok;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_range ? CONVERT : CHECK;
        end
      end
      CONVERT: begin
        if (conv_done) begin
          state_d = CHECK;
        end
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy = (state_q != IDLE) || conv_busy;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      range_err_q <= 1'b0;
    end else if (accept) begin
      range_err_q <= !in_range;
    end
  end

  assign presc_wrap = i_run && (presc_q == PRE_MAX);
  // Wraps while busy are swallowed: no increment, no tick.
  assign sec_inc    = presc_wrap && (state_q == IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc_q <= '0;
    end else if (!i_run || load_commit || presc_wrap) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  assign ss_nxt = bcd_inc(ss_q, 8'h59);
  assign mm_nxt = bcd_inc(mm_q, 8'h59);
  assign hh_nxt = bcd_inc(hh_q, 8'h23);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hh_q <= 8'h00;
      mm_q <= 8'h00;
      ss_q <= 8'h00;
    end else if (load_commit) begin
      hh_q <= cand_hh;
      mm_q <= cand_mm;
      ss_q <= cand_ss;
    end else if (sec_inc) begin
      ss_q <= ss_nxt[7:0];
      if (ss_nxt[8]) begin
        mm_q <= mm_nxt[7:0];
        if (mm_nxt[8]) begin
          hh_q <= hh_nxt[7:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      tick_q <= sec_inc;
      if (state_q == CHECK) begin
        err_q <= !load_ok;
      end
    end
  end

`ifdef CLOCK_12H_DISPLAY_EN
  assign o_hh_bcd = hour_to_12h(hh_q);
  assign o_pm     = (hh_q >= 8'h12);
`else
  assign o_hh_bcd = hh_q;
`endif
  assign o_mm_bcd   = mm_q;
  assign o_ss_bcd   = ss_q;
  assign o_sec_tick = tick_q;
  assign o_load_err = err_q;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Self-checking bench for clock_time_keeper with a 10-cycle second.
// Expected load results are queued when a load is driven and popped when busy drops.
module tb_clock_time_keeper;

  localparam int unsigned FREQ = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] setup;
  logic        load;
  logic        run;
  logic [7:0]  hh, mm, ss;
  logic        tick, busy, err;
`ifdef CLOCK_12H_DISPLAY_EN
  logic        pm;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       err;
    int         busy;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  clock_time_keeper #(
    .CLK_FREQ_HZ (FREQ),
    .SETUP_W     (40)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_setup_value (setup),
    .i_load        (load),
    .i_run         (run),
    .o_hh_bcd      (hh),
    .o_mm_bcd      (mm),
    .o_ss_bcd      (ss),
    .o_sec_tick    (tick),
    .o_busy        (busy),
`ifdef CLOCK_12H_DISPLAY_EN
    .o_pm          (pm),
`endif
    .o_load_err    (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hour value as the display should present it for a 24-hour BCD hour.
  function automatic logic [7:0] hh_disp(input logic [7:0] h);
`ifdef CLOCK_12H_DISPLAY_EN
    int b;
    b = int'(h[7:4]) * 10 + int'(h[3:0]);
    if (b == 0) b = 12;
    else if (b > 12) b = b - 12;
    return {4'(b / 10), 4'(b % 10)};
`else
    return h;
`endif
  endfunction

  task automatic check_time(input string tag, input logic [7:0] eh, input logic [7:0] em,
                            input logic [7:0] es);
    check({tag, "_hh"}, 32'(hh), 32'(hh_disp(eh)));
    check({tag, "_mm"}, 32'(mm), 32'(em));
    check({tag, "_ss"}, 32'(ss), 32'(es));
  endtask

  task automatic do_load(input string tag, input logic [39:0] v, input logic [7:0] eh,
                         input logic [7:0] em, input logic [7:0] es, input logic ee,
                         input int eb);
    exp_t e;
    int   n;
    e.hh = eh; e.mm = em; e.ss = es; e.err = ee; e.busy = eb;
    sb_q.push_back(e);
    @(negedge clk);
    setup = v;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    check({tag, "_busy_cycles"}, 32'(n), 32'(e.busy));
    check_time(tag, e.hh, e.mm, e.ss);
    check({tag, "_err"}, 32'(err), 32'(e.err));
  endtask

  initial begin
    int ticks;
    int wide;
    logic prev;
    rst   = 1'b1;
    run   = 1'b0;
    load  = 1'b0;
    setup = '0;
    repeat (2) @(negedge clk);
    check_time("reset", 8'h00, 8'h00, 8'h00);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    // Free run for one minute.
    rst   = 1'b0;
    run   = 1'b1;
    ticks = 0;
    wide  = 0;
    prev  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tick) ticks++;
      if (tick && prev) wide++;
      prev = tick;
    end
    check_time("minute", 8'h00, 8'h01, 8'h00);
    check("minute_ticks", 32'(ticks), 32'd60);
    check("minute_tick_wide", 32'(wide), 32'd0);

    do_load("ld123045", 40'd123045, 8'h12, 8'h30, 8'h45, 1'b0, 21);
    repeat (10) @(negedge clk);
    check("ld123045_plus1_ss", 32'(ss), 32'h46);
    check("ld123045_plus1_tick", 32'(tick), 32'd1);

    do_load("ld095959", 40'd95959, 8'h09, 8'h59, 8'h59, 1'b0, 21);
    repeat (10) @(negedge clk);
    check_time("carry_10h", 8'h10, 8'h00, 8'h00);

    do_load("ld235958", 40'd235958, 8'h23, 8'h59, 8'h58, 1'b0, 21);
    repeat (10) @(negedge clk);
    check_time("pre_midnight", 8'h23, 8'h59, 8'h59);
    repeat (10) @(negedge clk);
    check_time("midnight", 8'h00, 8'h00, 8'h00);

    // Frozen clock: loads still complete, time stays put afterwards.
    run = 1'b0;
    do_load("ld246000", 40'd246000, 8'h00, 8'h00, 8'h00, 1'b1, 21);
    do_load("ld1000000", 40'd1000000, 8'h00, 8'h00, 8'h00, 1'b1, 1);
    do_load("ld_hibit", 40'h10_0000_0001, 8'h00, 8'h00, 8'h00, 1'b1, 1);
    do_load("ld000001", 40'd1, 8'h00, 8'h00, 8'h01, 1'b0, 21);
    repeat (30) @(negedge clk);
    check_time("frozen", 8'h00, 8'h00, 8'h01);
    check("frozen_tick", 32'(tick), 32'd0);

    // Reset during conversion aborts without loading.
    @(negedge clk);
    setup = 40'd123045;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (9) @(negedge clk);
    check("midconv_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_time("midconv_rst", 8'h00, 8'h00, 8'h00);
    check("midconv_rst_busy", 32'(busy), 32'd0);
    check("midconv_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_time("after_rst", 8'h00, 8'h00, 8'h00);
    check("after_rst_busy", 32'(busy), 32'd0);

`ifdef CLOCK_12H_DISPLAY_EN
    do_load("h12_000000", 40'd0, 8'h00, 8'h00, 8'h00, 1'b0, 21);
    check("h12_000000_raw_hh", 32'(hh), 32'h12);
    check("h12_000000_pm", 32'(pm), 32'd0);
    do_load("h12_130000", 40'd130000, 8'h13, 8'h00, 8'h00, 1'b0, 21);
    check("h12_130000_raw_hh", 32'(hh), 32'h01);
    check("h12_130000_pm", 32'(pm), 32'd1);
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
